// File: rtl/bra_rs.sv
// Branch reservation station: age-ordered collapsing queue that wakes operands
// from the CDB and issues the oldest ready branch to the branch unit each cycle.
`ifndef ROB_ENTRY_WIDTH
`define ROB_ENTRY_WIDTH 4
`endif

module bra_rs #(
    parameter int DEPTH = 4,
    parameter int TAG_W = `ROB_ENTRY_WIDTH
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       disp_valid,
    input  logic [3:0]                 disp_op,
    input  logic [31:0]                disp_pc,
    input  logic [31:0]                disp_offset,
    input  logic [TAG_W-1:0]           disp_dest,
    input  logic                       disp_a_rdy,
    input  logic                       disp_b_rdy,
    input  logic [31:0]                disp_a_val,
    input  logic [31:0]                disp_b_val,
    input  logic [TAG_W-1:0]           disp_a_tag,
    input  logic [TAG_W-1:0]           disp_b_tag,
    output logic                       disp_ready,
    input  logic                       cdb_valid,
    input  logic [TAG_W-1:0]           cdb_tag,
    input  logic [31:0]                cdb_value,
    output logic [3:0]                 iss_op,
    output logic [31:0]                iss_srca,
    output logic [31:0]                iss_srcb,
    output logic [31:0]                iss_pc,
    output logic [31:0]                iss_offset,
    output logic [TAG_W-1:0]           iss_dest,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int IW = $clog2(DEPTH);
    localparam int CW = IW + 1;

    logic [CW-1:0]    count_q, count_d;
    logic [DEPTH-1:0] a_rdy_q, a_rdy_d, b_rdy_q, b_rdy_d;
    logic [3:0]       op_q   [DEPTH];
    logic [3:0]       op_d   [DEPTH];
    logic [31:0]      pc_q   [DEPTH];
    logic [31:0]      pc_d   [DEPTH];
    logic [31:0]      off_q  [DEPTH];
    logic [31:0]      off_d  [DEPTH];
    logic [31:0]      a_val_q[DEPTH];
    logic [31:0]      a_val_d[DEPTH];
    logic [31:0]      b_val_q[DEPTH];
    logic [31:0]      b_val_d[DEPTH];
    logic [TAG_W-1:0] dest_q [DEPTH];
    logic [TAG_W-1:0] dest_d [DEPTH];
    logic [TAG_W-1:0] a_tag_q[DEPTH];
    logic [TAG_W-1:0] a_tag_d[DEPTH];
    logic [TAG_W-1:0] b_tag_q[DEPTH];
    logic [TAG_W-1:0] b_tag_d[DEPTH];

    logic [DEPTH-1:0] a_rdy_c, b_rdy_c;
    logic [31:0]      a_val_c[DEPTH];
    logic [31:0]      b_val_c[DEPTH];
    logic             iss_vld;
    logic [IW-1:0]    sel;
    logic             accept;
    logic [CW-1:0]    cnt_mid;

    assign count      = count_q;
    assign disp_ready = (count_q < CW'(DEPTH));
    assign accept     = disp_valid && disp_ready && !flush;
    assign cnt_mid    = count_q - CW'(iss_vld);

    // Descending scan so the lowest (oldest) ready slot wins.
    always_comb begin
        iss_vld = 1'b0;
        sel     = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (CW'(i) < count_q && a_rdy_q[i] && b_rdy_q[i]) begin
                iss_vld = 1'b1;
                sel     = IW'(i);
            end
        end
    end

    always_comb begin
        iss_op     = '0;
        iss_srca   = '0;
        iss_srcb   = '0;
        iss_pc     = '0;
        iss_offset = '0;
        iss_dest   = '0;
        if (iss_vld) begin
            iss_op     = op_q[sel];
            iss_srca   = a_val_q[sel];
            iss_srcb   = b_val_q[sel];
            iss_pc     = pc_q[sel];
            iss_offset = off_q[sel];
            iss_dest   = dest_q[sel];
        end
    end

    // CDB wakeup of occupied entries, applied before the collapse so it survives the shift.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            a_rdy_c[i] = a_rdy_q[i];
            b_rdy_c[i] = b_rdy_q[i];
            a_val_c[i] = a_val_q[i];
            b_val_c[i] = b_val_q[i];
            if (cdb_valid && CW'(i) < count_q) begin
                if (!a_rdy_q[i] && a_tag_q[i] == cdb_tag) begin
                    a_rdy_c[i] = 1'b1;
                    a_val_c[i] = cdb_value;
                end
                if (!b_rdy_q[i] && b_tag_q[i] == cdb_tag) begin
                    b_rdy_c[i] = 1'b1;
                    b_val_c[i] = cdb_value;
                end
            end
        end
    end

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            int src;
            src = (iss_vld && IW'(i) >= sel && i < DEPTH - 1) ? i + 1 : i;
            op_d[i]    = op_q[src];
            pc_d[i]    = pc_q[src];
            off_d[i]   = off_q[src];
            dest_d[i]  = dest_q[src];
            a_tag_d[i] = a_tag_q[src];
            b_tag_d[i] = b_tag_q[src];
            a_rdy_d[i] = a_rdy_c[src];
            b_rdy_d[i] = b_rdy_c[src];
            a_val_d[i] = a_val_c[src];
            b_val_d[i] = b_val_c[src];
            if (accept && CW'(i) == cnt_mid) begin
                op_d[i]    = disp_op;
                pc_d[i]    = disp_pc;
                off_d[i]   = disp_offset;
                dest_d[i]  = disp_dest;
                a_tag_d[i] = disp_a_tag;
                b_tag_d[i] = disp_b_tag;
                a_rdy_d[i] = disp_a_rdy || (cdb_valid && cdb_tag == disp_a_tag);
                b_rdy_d[i] = disp_b_rdy || (cdb_valid && cdb_tag == disp_b_tag);
                a_val_d[i] = disp_a_rdy ? disp_a_val : cdb_value;
                b_val_d[i] = disp_b_rdy ? disp_b_val : cdb_value;
            end
        end
        count_d = flush ? '0 : cnt_mid + CW'(accept);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
            a_rdy_q <= '0;
            b_rdy_q <= '0;
        end else begin
            count_q <= count_d;
            a_rdy_q <= a_rdy_d;
            b_rdy_q <= b_rdy_d;
        end
    end

    // Payload is only meaningful below count_q, so it needs no reset.
    always_ff @(posedge clk) begin
        op_q    <= op_d;
        pc_q    <= pc_d;
        off_q   <= off_d;
        dest_q  <= dest_d;
        a_tag_q <= a_tag_d;
        b_tag_q <= b_tag_d;
        a_val_q <= a_val_d;
        b_val_q <= b_val_d;
    end

endmodule

// File: tb/tb_bra_rs.sv
// Scoreboard bench for bra_rs: a queue-based station model predicts each cycle's
// issue, count and disp_ready; a negedge monitor compares against the DUT.
module tb_bra_rs;
    localparam int DEPTH = 4;
    localparam int TAG_W = 4;
    localparam int CW    = $clog2(DEPTH) + 1;
    localparam logic [3:0] BEQ = 4'd1, BNE = 4'd2, BLT = 4'd3, JALR = 4'd8;

    logic             clk = 1'b0;
    logic             rst, flush, disp_valid, disp_a_rdy, disp_b_rdy, cdb_valid;
    logic [3:0]       disp_op;
    logic [31:0]      disp_pc, disp_offset, disp_a_val, disp_b_val, cdb_value;
    logic [TAG_W-1:0] disp_dest, disp_a_tag, disp_b_tag, cdb_tag;
    logic             disp_ready;
    logic [3:0]       iss_op;
    logic [31:0]      iss_srca, iss_srcb, iss_pc, iss_offset;
    logic [TAG_W-1:0] iss_dest;
    logic [CW-1:0]    count;

    bra_rs #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .disp_valid(disp_valid), .disp_op(disp_op), .disp_pc(disp_pc),
        .disp_offset(disp_offset), .disp_dest(disp_dest),
        .disp_a_rdy(disp_a_rdy), .disp_b_rdy(disp_b_rdy),
        .disp_a_val(disp_a_val), .disp_b_val(disp_b_val),
        .disp_a_tag(disp_a_tag), .disp_b_tag(disp_b_tag),
        .disp_ready(disp_ready),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_value(cdb_value),
        .iss_op(iss_op), .iss_srca(iss_srca), .iss_srcb(iss_srcb),
        .iss_pc(iss_pc), .iss_offset(iss_offset), .iss_dest(iss_dest),
        .count(count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]       op;
        logic [31:0]      pc, off, av, bv;
        logic [TAG_W-1:0] dest, at, bt;
        bit               ar, br;
    } ent_t;

    typedef struct {
        logic [3:0]       op;
        logic [31:0]      srca, srcb, pc, off;
        logic [TAG_W-1:0] dest;
    } iss_t;

    ent_t S[$];
    iss_t exp_q[$];
    iss_t mon_e;
    int   errors = 0;
    int   checks = 0;
    int   exp_count = 0;
    bit   exp_drdy = 1'b1;
    bit   started = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Predict this cycle's outputs from the model, then advance the model over the edge.
    task automatic step();
        int   sel;
        iss_t e;
        ent_t n;
        bit   acc;
        sel = -1;
        for (int i = 0; i < S.size(); i++) begin
            if (S[i].ar && S[i].br) begin
                sel = i;
                break;
            end
        end
        if (sel >= 0) begin
            e.op = S[sel].op;  e.srca = S[sel].av; e.srcb = S[sel].bv;
            e.pc = S[sel].pc;  e.off = S[sel].off; e.dest = S[sel].dest;
            exp_q.push_back(e);
        end
        exp_count = S.size();
        exp_drdy  = (S.size() < DEPTH);
        if (rst || flush) begin
            S.delete();
        end else begin
            acc = disp_valid && (S.size() < DEPTH);
            if (cdb_valid) begin
                foreach (S[i]) begin
                    if (!S[i].ar && S[i].at == cdb_tag) begin S[i].ar = 1'b1; S[i].av = cdb_value; end
                    if (!S[i].br && S[i].bt == cdb_tag) begin S[i].br = 1'b1; S[i].bv = cdb_value; end
                end
            end
            if (sel >= 0) S.delete(sel);
            if (acc) begin
                n.op = disp_op; n.pc = disp_pc; n.off = disp_offset; n.dest = disp_dest;
                n.at = disp_a_tag; n.bt = disp_b_tag;
                n.ar = disp_a_rdy || (cdb_valid && cdb_tag == disp_a_tag);
                n.br = disp_b_rdy || (cdb_valid && cdb_tag == disp_b_tag);
                n.av = disp_a_rdy ? disp_a_val : cdb_value;
                n.bv = disp_b_rdy ? disp_b_val : cdb_value;
                S.push_back(n);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        rst = 1'b0; flush = 1'b0; disp_valid = 1'b0; cdb_valid = 1'b0;
        disp_op = '0; disp_pc = '0; disp_offset = '0; disp_dest = '0;
        disp_a_rdy = 1'b1; disp_b_rdy = 1'b1; disp_a_val = '0; disp_b_val = '0;
        disp_a_tag = '0; disp_b_tag = '0; cdb_tag = '0; cdb_value = '0;
    endtask

    task automatic set_disp(input logic [3:0] op, input logic [31:0] pc, input logic [31:0] off,
                            input logic [TAG_W-1:0] dest,
                            input bit ar, input logic [31:0] av, input logic [TAG_W-1:0] at,
                            input bit br, input logic [31:0] bv, input logic [TAG_W-1:0] bt);
        disp_valid = 1'b1; disp_op = op; disp_pc = pc; disp_offset = off; disp_dest = dest;
        disp_a_rdy = ar; disp_a_val = av; disp_a_tag = at;
        disp_b_rdy = br; disp_b_val = bv; disp_b_tag = bt;
    endtask

    task automatic set_cdb(input logic [TAG_W-1:0] tag, input logic [31:0] val);
        cdb_valid = 1'b1; cdb_tag = tag; cdb_value = val;
    endtask

    always @(negedge clk) begin
        if (started) begin
            check("count", 32'(count), 32'(exp_count));
            check("disp_ready", 32'(disp_ready), 32'(exp_drdy));
            if (iss_op != 4'd0) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_issue actual_op=%0h expected=idle at %0t", iss_op, $time);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("iss_op", 32'(iss_op), 32'(mon_e.op));
                    check("iss_srca", iss_srca, mon_e.srca);
                    check("iss_srcb", iss_srcb, mon_e.srcb);
                    check("iss_pc", iss_pc, mon_e.pc);
                    check("iss_offset", iss_offset, mon_e.off);
                    check("iss_dest", 32'(iss_dest), 32'(mon_e.dest));
                end
            end else begin
                check("idle_outputs_zero", iss_srca | iss_srcb | iss_pc | iss_offset | 32'(iss_dest), 32'd0);
                if (exp_q.size() != 0) begin
                    mon_e = exp_q.pop_front();
                    checks++;
                    errors++;
                    $display("FAIL missed_issue actual_op=0 expected_op=%0h at %0t", mon_e.op, $time);
                end
            end
        end
    end

    initial begin
        idle_inputs();
        rst = 1'b1;
        @(posedge clk);
        #1;
        started = 1'b1;
        step();
        idle_inputs();
        step();

        // Both operands ready: issues the cycle after dispatch.
        set_disp(BEQ, 32'h100, 32'h20, 4'd3, 1'b1, 32'd5, 4'd0, 1'b1, 32'd5, 4'd0);
        step();
        idle_inputs();
        step();
        step();

        // Operand A waits on tag 2, woken by a later broadcast.
        set_disp(BNE, 32'h200, 32'h8, 4'd1, 1'b0, 32'd0, 4'd2, 1'b1, 32'h11, 4'd0);
        step();
        idle_inputs();
        step();
        step();
        set_cdb(4'd2, 32'h7);
        step();
        idle_inputs();
        step();
        step();

        // Dispatch-time bypass from a same-cycle broadcast.
        set_disp(BLT, 32'h300, 32'h4, 4'd5, 1'b0, 32'd0, 4'd4, 1'b1, 32'h1, 4'd0);
        set_cdb(4'd4, 32'h9);
        step();
        idle_inputs();
        step();
        step();

        // Fill: slot 0 waits on tag 6, slots 1-3 wait on tag 5; a fifth dispatch is dropped.
        set_disp(BEQ, 32'h400, 32'h0, 4'd8, 1'b0, 32'd0, 4'd6, 1'b1, 32'h40, 4'd0);
        step();
        for (int k = 1; k < 4; k++) begin
            set_disp(BNE, 32'h400 + 32'(k * 4), 32'(k), 4'(8 + k), 1'b1, 32'(k), 4'd0, 1'b0, 32'd0, 4'd5);
            step();
        end
        set_disp(JALR, 32'h500, 32'h0, 4'd15, 1'b1, 32'h1, 4'd0, 1'b1, 32'h2, 4'd0);
        step();
        idle_inputs();
        set_cdb(4'd5, 32'h55);
        step();
        idle_inputs();
        for (int k = 0; k < 4; k++) step();
        set_cdb(4'd6, 32'h66);
        step();
        idle_inputs();
        step();
        step();

        // Three pending entries, then flush together with a dispatch.
        for (int k = 0; k < 3; k++) begin
            set_disp(BEQ, 32'h600 + 32'(k * 4), 32'h10, 4'(k), 1'b0, 32'd0, 4'd7, 1'b1, 32'd0, 4'd0);
            step();
        end
        idle_inputs();
        flush = 1'b1;
        set_disp(BNE, 32'h700, 32'h10, 4'd9, 1'b1, 32'h3, 4'd0, 1'b1, 32'h3, 4'd0);
        step();
        idle_inputs();
        step();
        step();

        // Reset with two entries pending: neither may ever issue.
        for (int k = 0; k < 2; k++) begin
            set_disp(BLT, 32'h800 + 32'(k * 4), 32'h2, 4'(k + 2), 1'b0, 32'd0, 4'd10, 1'b1, 32'd0, 4'd0);
            step();
        end
        idle_inputs();
        rst = 1'b1;
        set_cdb(4'd10, 32'hA);
        step();
        idle_inputs();
        step();
        step();

        // Randomized traffic.
        for (int c = 0; c < 3000; c++) begin
            idle_inputs();
            if ($urandom_range(0, 99) < 60) begin
                set_disp(4'($urandom_range(1, 15)), $urandom, $urandom, 4'($urandom_range(0, 15)),
                         1'($urandom_range(0, 1)), $urandom, 4'($urandom_range(0, 15)),
                         1'($urandom_range(0, 1)), $urandom, 4'($urandom_range(0, 15)));
            end
            if ($urandom_range(0, 99) < 50) set_cdb(4'($urandom_range(0, 15)), $urandom);
            flush = ($urandom_range(0, 99) < 3);
            rst   = ($urandom_range(0, 199) < 2);
            step();
        end
        idle_inputs();
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
